// File: rtl/uart_transceiver_pkg.sv
// State encodings shared by the UART transmitter and receiver.
package uart_transceiver_pkg;
    typedef enum logic [0:0] {TX_IDLE, TX_SEND} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_WAIT_HIGH} rx_state_e;
endpackage

// File: rtl/uart_transceiver_rx.sv
// 8N1 receiver: mid-bit sampling after a 2-flop synchronizer, one-deep output holding register.
module uart_rx
    import uart_transceiver_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME = SYMBOL_EDGE_TIME / 2;
    localparam int CW = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CW-1:0] CNT_SAMPLE = CW'(SAMPLE_TIME);

    rx_state_e     state_q, state_d;
    logic          sync1_q, sync1_d, sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          accept;

    always_comb begin
        sync1_d = serial_in;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        accept  = valid_q && data_out_ready;
        valid_d = accept ? 1'b0 : valid_q;
        case (state_q)
            RX_IDLE: begin
                if (!sync2_q) begin
                    state_d = RX_RECV;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            RX_RECV: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    bit_d = bit_q + 4'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (cnt_q == CNT_SAMPLE) begin
                    if (bit_q == 4'd0) begin
                        if (sync2_q) state_d = RX_IDLE;
                    end else if (bit_q <= 4'd8) begin
                        shift_d = {sync2_q, shift_q[7:1]};
                    end else if (sync2_q) begin
                        state_d = RX_IDLE;
                        // A completed byte is dropped when the previous one is still unconsumed.
                        if (!valid_q || accept) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
                    end else begin
                        state_d = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (sync2_q) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out       = data_q;
    assign data_out_valid = valid_q;
endmodule

// File: rtl/uart_transceiver_tx.sv
// 8N1 transmitter: latches a byte on handshake, drives start, 8 data bits LSB first, stop.
module uart_tx
    import uart_transceiver_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam int FRAME_BITS = 10;
    localparam logic [CW-1:0] CNT_LAST = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [8:0]    shift_q, shift_d;
    logic          ready_q, ready_d;
    logic          out_q, out_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ready_d = ready_q;
        out_d   = out_q;
        case (state_q)
            TX_IDLE: begin
                ready_d = 1'b1;
                if (data_in_valid && ready_q) begin
                    state_d = TX_SEND;
                    // Stop bit rides in the top of the shift register behind the data.
                    shift_d = {1'b1, data_in};
                    out_d   = 1'b0;
                    cnt_d   = '0;
                    bit_d   = '0;
                    ready_d = 1'b0;
                end
            end
            TX_SEND: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = TX_IDLE;
                        ready_d = 1'b1;
                        out_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        out_d   = shift_q[0];
                        shift_d = {1'b1, shift_q[8:1]};
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ready_q <= 1'b0;
            out_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ready_q <= ready_d;
            out_q   <= out_d;
        end
    end

    assign data_in_ready = ready_q;
    assign serial_out    = out_q;
endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: independent transmitter and receiver sharing only clock and reset.
module uart_transceiver #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    input  logic       serial_in,
    output logic       serial_out
);
    uart_tx #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) u_tx (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .serial_out    (serial_out)
    );

    uart_rx #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) u_rx (
        .clk            (clk),
        .reset          (reset),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
    );
endmodule

// File: tb/tb_uart_transceiver.sv
// Bench: DUT transmits into a peer instance; DUT receiver is driven by a bit-banged line.
module tb_uart_transceiver;
    localparam int CLK_HZ = 125_000_000;
    localparam int BAUD   = 1_250_000;
    localparam int S      = CLK_HZ / BAUD;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] dut_din = 8'h00;
    logic       dut_din_valid = 1'b0;
    logic       dut_din_ready;
    logic [7:0] dut_dout;
    logic       dut_dout_valid;
    logic       dut_dout_ready = 1'b0;
    logic       rx_line = 1'b1;
    logic       dut_tx;

    logic [7:0] peer_din = 8'h00;
    logic       peer_din_valid = 1'b0;
    logic       peer_din_ready;
    logic [7:0] peer_dout;
    logic       peer_dout_valid;
    logic       peer_dout_ready = 1'b0;
    logic       peer_tx;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    uart_transceiver #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD)) u_dut (
        .clk(clk), .reset(reset),
        .data_in(dut_din), .data_in_valid(dut_din_valid), .data_in_ready(dut_din_ready),
        .data_out(dut_dout), .data_out_valid(dut_dout_valid), .data_out_ready(dut_dout_ready),
        .serial_in(rx_line), .serial_out(dut_tx)
    );

    uart_transceiver #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD)) u_peer (
        .clk(clk), .reset(reset),
        .data_in(peer_din), .data_in_valid(peer_din_valid), .data_in_ready(peer_din_ready),
        .data_out(peer_dout), .data_out_valid(peer_dout_valid), .data_out_ready(peer_dout_ready),
        .serial_in(dut_tx), .serial_out(peer_tx)
    );

    // Returns just after the accept edge; data_in is scrambled afterwards to prove it is latched.
    task automatic send_byte(input logic [7:0] b, input bit push, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        dut_din = b;
        dut_din_valid = 1'b1;
        for (int i = 0; i < 12 * S; i++) begin
            if (dut_din_ready === 1'b1) begin
                @(posedge clk);
                #1;
                dut_din_valid = 1'b0;
                dut_din = 8'($urandom);
                if (push) exp_q.push_back(b);
                $display("tx byte 0x%02h", b);
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        dut_din_valid = 1'b0;
    endtask

    task automatic wait_peer_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (peer_dout_valid === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx_line = bits[i];
            repeat (S - 1) @(negedge clk);
        end
        @(negedge clk);
        rx_line = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (50) @(negedge clk);
        checks++; if (dut_tx !== 1'b1) begin errors++; $display("FAIL reset_serial_out got %b want 1", dut_tx); end
        checks++; if (dut_din_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", dut_din_ready); end
        checks++; if (dut_dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", dut_dout_valid); end
        checks++; if (dut_dout !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", dut_dout); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (dut_din_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", dut_din_ready); end
        checks++; if (peer_din_ready !== 1'b1 || peer_tx !== 1'b1) begin
            errors++; $display("FAIL reset_peer_idle got ready=%b tx=%b want 1 1", peer_din_ready, peer_tx);
        end
    endtask

    task automatic test_tx_waveform();
        bit ok;
        logic [7:0] b;
        logic expb;
        int bad;
        b = 8'h7a;
        send_byte(b, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL tx_send_timeout got 0 want 1"); end
        for (int bi = 0; bi < 10; bi++) begin
            expb = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
            bad = 0;
            for (int c = 0; c < S; c++) begin
                @(negedge clk);
                if (dut_tx !== expb) bad++;
                if (bi == 0 && c == 0) begin
                    checks++; if (dut_din_ready !== 1'b0) begin errors++; $display("FAIL tx_busy_ready got %b want 0", dut_din_ready); end
                end
            end
            checks++; if (bad != 0) begin errors++; $display("FAIL tx_bit%0d got %0d wrong cycles want 0 (level %b)", bi, bad, expb); end
        end
        checks++; if (dut_din_ready !== 1'b0) begin errors++; $display("FAIL tx_ready_early got %b want 0", dut_din_ready); end
        @(negedge clk);
        checks++; if (dut_din_ready !== 1'b1) begin errors++; $display("FAIL tx_ready_return got %b want 1", dut_din_ready); end
        wait_peer_valid(2 * S, ok);
        checks++; if (!ok || exp_q.size() == 0 || peer_dout !== exp_q[0]) begin
            errors++; $display("FAIL tx_peer_rx got valid=%b data=%h want 1 7a", ok, peer_dout);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        peer_dout_ready = 1'b1;
        @(negedge clk);
        peer_dout_ready = 1'b0;
        checks++; if (peer_dout_valid !== 1'b0) begin errors++; $display("FAIL tx_peer_consume got %b want 0", peer_dout_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] msg[4];
        msg = '{8'h31, 8'h35, 8'h31, 8'h3e};
        fork
            begin
                bit ok;
                for (int i = 0; i < 4; i++) begin
                    send_byte(msg[i], 1'b1, ok);
                    checks++; if (!ok) begin errors++; $display("FAIL b2b_send%0d got timeout want accept", i); end
                end
            end
            begin
                bit ok;
                logic [7:0] e;
                for (int i = 0; i < 4; i++) begin
                    wait_peer_valid(14 * S, ok);
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                    checks++; if (!ok || peer_dout !== e) begin
                        errors++; $display("FAIL b2b_rx%0d got valid=%b data=%h want %h", i, ok, peer_dout, e);
                    end
                    $display("rx byte 0x%02h", peer_dout);
                    peer_dout_ready = 1'b1;
                    @(negedge clk);
                    peer_dout_ready = 1'b0;
                    checks++; if (peer_dout_valid !== 1'b0) begin errors++; $display("FAIL b2b_dup%0d got %b want 0", i, peer_dout_valid); end
                end
            end
        join
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_overrun();
        bit ok;
        logic [7:0] e;
        send_byte(8'h55, 1'b1, ok);
        send_byte(8'haa, 1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovr_send got timeout want accept"); end
        repeat (10 * S + 10) @(negedge clk);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (peer_dout_valid !== 1'b1 || peer_dout !== e) begin
            errors++; $display("FAIL ovr_hold got valid=%b data=%h want 1 %h", peer_dout_valid, peer_dout, e);
        end
        $display("rx byte 0x%02h (held)", peer_dout);
        peer_dout_ready = 1'b1;
        @(negedge clk);
        peer_dout_ready = 1'b0;
        checks++; if (peer_dout_valid !== 1'b0) begin errors++; $display("FAIL ovr_consume got %b want 0", peer_dout_valid); end
        wait_peer_valid(2 * S, ok);
        checks++; if (ok) begin errors++; $display("FAIL ovr_dropped got valid data=%h want none", peer_dout); end
    endtask

    task automatic test_rx_errors();
        int seen;
        bit ok;
        logic [7:0] e;
        @(negedge clk);
        rx_line = 1'b0;
        repeat (S / 4) @(negedge clk);
        rx_line = 1'b1;
        seen = 0;
        repeat (12 * S) begin
            @(negedge clk);
            if (dut_dout_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rx_glitch got %0d valid cycles want 0", seen); end
        drive_frame(8'h5a, 1'b0);
        seen = 0;
        repeat (2 * S) begin
            @(negedge clk);
            if (dut_dout_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rx_framing got %0d valid cycles want 0", seen); end
        exp_q.push_back(8'h7a);
        drive_frame(8'h7a, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 2 * S; i++) begin
            if (dut_dout_valid === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (!ok || dut_dout !== e) begin
            errors++; $display("FAIL rx_recover got valid=%b data=%h want 1 %h", ok, dut_dout, e);
        end
        $display("rx byte 0x%02h (dut)", dut_dout);
        dut_dout_ready = 1'b1;
        @(negedge clk);
        dut_dout_ready = 1'b0;
        checks++; if (dut_dout_valid !== 1'b0) begin errors++; $display("FAIL rx_consume got %b want 0", dut_dout_valid); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        logic [7:0] e;
        send_byte(8'hc3, 1'b0, ok);
        repeat (5 * S) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (dut_tx !== 1'b1) begin errors++; $display("FAIL mid_reset_tx got %b want 1", dut_tx); end
        checks++; if (dut_din_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready got %b want 0", dut_din_ready); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (dut_din_ready !== 1'b1 || peer_dout_valid !== 1'b0) begin
            errors++; $display("FAIL mid_release got ready=%b peer_valid=%b want 1 0", dut_din_ready, peer_dout_valid);
        end
        send_byte(8'h3c, 1'b1, ok);
        wait_peer_valid(12 * S, ok);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (!ok || peer_dout !== e) begin
            errors++; $display("FAIL mid_resend got valid=%b data=%h want 1 %h", ok, peer_dout, e);
        end
        $display("rx byte 0x%02h", peer_dout);
        peer_dout_ready = 1'b1;
        @(negedge clk);
        peer_dout_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tx_waveform();
        test_back_to_back();
        test_overrun();
        test_rx_errors();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
